// File: rtl/conv_tile_loader.sv
// Serial byte loader for the 3x3 conv stage: stages a filter and a tile, then hands both off
// as one parallel job under valid/ready, with staging double-buffered against the output.
module conv_tile_loader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TILE_N = 4,
  parameter int unsigned FILT_N = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pix_valid,
  input  logic [DATA_W-1:0]                 pix_data,
  output logic                              pix_ready,
  input  logic                              reload_filter,
  output logic                              tile_valid,
  input  logic                              tile_ready,
  output logic [TILE_N*TILE_N*DATA_W-1:0]   tile_data,
  output logic [FILT_N*FILT_N*DATA_W-1:0]   filter_data,
  output logic [7:0]                        tiles_sent
);

  localparam int unsigned TILE_SZ = TILE_N * TILE_N;
  localparam int unsigned FILT_SZ = FILT_N * FILT_N;
  localparam int unsigned TIDX_W  = $clog2(TILE_SZ);
  localparam int unsigned FIDX_W  = $clog2(FILT_SZ);
  localparam int unsigned CNT_W   = (TIDX_W > FIDX_W) ? TIDX_W : FIDX_W;

  typedef enum logic {FILT, TILE} phase_t;

  phase_t                      phase, phase_nxt;
  logic [CNT_W-1:0]            cnt;
  logic                        stg_full;
  logic [DATA_W-1:0]           tile_stg [TILE_SZ];
  logic [DATA_W-1:0]           filt_stg [FILT_SZ];
  logic [TILE_SZ*DATA_W-1:0]   tile_flat;
  logic [FILT_SZ*DATA_W-1:0]   filt_flat;
  logic                        acc, xfer, filt_last, tile_last, handshake;

  assign pix_ready = !stg_full;

  // Handshake qualifiers; a byte is never accepted on the same edge as a job transfer.
  always_comb begin
    acc       = pix_valid && !stg_full;
    xfer      = stg_full && (!tile_valid || tile_ready);
    handshake = tile_valid && tile_ready;
    filt_last = acc && (phase == FILT) && (cnt == CNT_W'(FILT_SZ - 1));
    tile_last = acc && (phase == TILE) && (cnt == CNT_W'(TILE_SZ - 1));
  end

  // Slot 0 lands in the most significant byte of each bus.
  always_comb begin
    tile_flat = '0;
    filt_flat = '0;
    for (int unsigned i = 0; i < TILE_SZ; i++)
      tile_flat[(TILE_SZ-1-i)*DATA_W +: DATA_W] = tile_stg[i];
    for (int unsigned i = 0; i < FILT_SZ; i++)
      filt_flat[(FILT_SZ-1-i)*DATA_W +: DATA_W] = filt_stg[i];
  end

  always_ff @(posedge clk) begin
    if (rst) phase <= FILT;
    else     phase <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase;
    if (xfer)           phase_nxt = reload_filter ? FILT : TILE;
    else if (filt_last) phase_nxt = TILE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      stg_full    <= 1'b0;
      tile_valid  <= 1'b0;
      tile_data   <= '0;
      filter_data <= '0;
      tiles_sent  <= '0;
      for (int unsigned i = 0; i < TILE_SZ; i++) tile_stg[i] <= '0;
      for (int unsigned i = 0; i < FILT_SZ; i++) filt_stg[i] <= '0;
    end else begin
      if (acc) begin
        if (phase == FILT) filt_stg[FIDX_W'(cnt)] <= pix_data;
        else               tile_stg[TIDX_W'(cnt)] <= pix_data;
        cnt <= (filt_last || tile_last) ? '0 : cnt + CNT_W'(1);
        if (tile_last) stg_full <= 1'b1;
      end
      // Filter staging is kept across transfers so a filter is reused until reloaded.
      if (xfer) begin
        tile_data   <= tile_flat;
        filter_data <= filt_flat;
        tile_valid  <= 1'b1;
        stg_full    <= 1'b0;
      end else if (handshake) begin
        tile_valid <= 1'b0;
      end
      if (handshake) tiles_sent <= tiles_sent + 8'd1;
    end
  end

endmodule

// File: tb/tb_conv_tile_loader.sv
// Directed bench for conv_tile_loader: load, backpressure, reload, gapped stream, reset, wrap.
module tb_conv_tile_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         pix_valid;
  logic [7:0]   pix_data;
  logic         pix_ready;
  logic         reload_filter;
  logic         tile_valid;
  logic         tile_ready;
  logic [127:0] tile_data;
  logic [71:0]  filter_data;
  logic [7:0]   tiles_sent;

  int errors = 0;
  int checks = 0;

  localparam logic [71:0]  F1 = 72'h010203040506070809;
  localparam logic [71:0]  F2 = 72'hF1F2F3F4F5F6F7F8F9;
  localparam logic [71:0]  F3 = 72'h818283848586878889;
  localparam logic [71:0]  F4 = 72'hC0C1C2C3C4C5C6C7C8;
  localparam logic [127:0] T1 = 128'h0A0B0C0D0E0F10111213141516171819;
  localparam logic [127:0] T2 = 128'h404142434445464748494A4B4C4D4E4F;
  localparam logic [127:0] T3 = 128'h505152535455565758595A5B5C5D5E5F;
  localparam logic [127:0] T4 = 128'h606162636465666768696A6B6C6D6E6F;
  localparam logic [127:0] T5 = 128'h707172737475767778797A7B7C7D7E7F;
  localparam logic [127:0] T6 = 128'h8A8B8C8D8E8F90919293949596979899;

  conv_tile_loader dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .reload_filter(reload_filter), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_data(tile_data), .filter_data(filter_data), .tiles_sent(tiles_sent)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one byte, waiting a bounded time for pix_ready, then clock it in.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    pix_valid = 1'b1;
    pix_data  = b;
    while (!pix_ready && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (!pix_ready) begin
      errors++;
      $display("FAIL send_timeout byte=%h pix_ready=%b required 1", b, pix_ready);
    end
    step();
  endtask

  function automatic logic [7:0] tile_byte(input int j, input int i);
    return (i == 0) ? 8'(j) : 8'(i * 17 + j);
  endfunction

  function automatic logic [127:0] exp_tile(input int j);
    logic [127:0] t = '0;
    for (int i = 0; i < 16; i++) t[(15-i)*8 +: 8] = tile_byte(j, i);
    return t;
  endfunction

  task automatic test_reset();
    rst = 1'b1; pix_valid = 1'b0; pix_data = '0; reload_filter = 1'b0; tile_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", tile_valid); end
    checks++; if (tile_data !== '0) begin errors++; $display("FAIL rst_tile got %h exp 0", tile_data); end
    checks++; if (filter_data !== '0) begin errors++; $display("FAIL rst_filter got %h exp 0", filter_data); end
    checks++; if (tiles_sent !== 8'd0) begin errors++; $display("FAIL rst_sent got %0d exp 0", tiles_sent); end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", pix_ready); end
  endtask

  task automatic test_first_load();
    for (int b = 1; b <= 25; b++) send_byte(8'(b));
    pix_valid = 1'b0;
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL t1_latency_valid got %b exp 0", tile_valid); end
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL t1_full_ready got %b exp 0", pix_ready); end
    step();
    checks++; if (tile_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b exp 1", tile_valid); end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_back got %b exp 1", pix_ready); end
    checks++; if (filter_data !== F1) begin errors++; $display("FAIL t1_filter got %h exp %h", filter_data, F1); end
    checks++; if (tile_data !== T1) begin errors++; $display("FAIL t1_tile got %h exp %h", tile_data, T1); end
    checks++; if (tiles_sent !== 8'd0) begin errors++; $display("FAIL t1_sent got %0d exp 0", tiles_sent); end
  endtask

  task automatic test_backpressure();
    for (int b = 8'h40; b <= 8'h4F; b++) send_byte(8'(b));
    pix_valid = 1'b1; pix_data = 8'hEE;
    step(); step(); step();
    checks++; if (pix_ready !== 1'b0) begin errors++; $display("FAIL t2_ready_low got %b exp 0", pix_ready); end
    checks++; if (tile_data !== T1) begin errors++; $display("FAIL t2_tile_hold got %h exp %h", tile_data, T1); end
    checks++; if (tile_valid !== 1'b1) begin errors++; $display("FAIL t2_valid_hold got %b exp 1", tile_valid); end
    pix_valid = 1'b0;
    tile_ready = 1'b1;
    step();
    tile_ready = 1'b0;
    checks++; if (tile_valid !== 1'b1) begin errors++; $display("FAIL t2_valid got %b exp 1", tile_valid); end
    checks++; if (tile_data !== T2) begin errors++; $display("FAIL t2_tile got %h exp %h", tile_data, T2); end
    checks++; if (tiles_sent !== 8'd1) begin errors++; $display("FAIL t2_sent got %0d exp 1", tiles_sent); end
    checks++; if (filter_data !== F1) begin errors++; $display("FAIL t2_filter got %h exp %h", filter_data, F1); end
    checks++; if (pix_ready !== 1'b1) begin errors++; $display("FAIL t2_ready got %b exp 1", pix_ready); end
  endtask

  task automatic test_reload();
    for (int b = 8'h50; b <= 8'h5F; b++) send_byte(8'(b));
    pix_valid = 1'b0;
    reload_filter = 1'b1; tile_ready = 1'b1;
    step();
    reload_filter = 1'b0; tile_ready = 1'b0;
    checks++; if (tile_data !== T3) begin errors++; $display("FAIL t3_tile_noreload got %h exp %h", tile_data, T3); end
    checks++; if (filter_data !== F1) begin errors++; $display("FAIL t3_filter_kept got %h exp %h", filter_data, F1); end
    checks++; if (tiles_sent !== 8'd2) begin errors++; $display("FAIL t3_sent2 got %0d exp 2", tiles_sent); end
    for (int b = 8'hF1; b <= 8'hF9; b++) send_byte(8'(b));
    checks++; if (filter_data !== F1) begin errors++; $display("FAIL t3_filter_early got %h exp %h", filter_data, F1); end
    for (int b = 8'h60; b <= 8'h6F; b++) send_byte(8'(b));
    pix_valid = 1'b0;
    tile_ready = 1'b1;
    step();
    checks++; if (filter_data !== F2) begin errors++; $display("FAIL t3_filter_new got %h exp %h", filter_data, F2); end
    checks++; if (tile_data !== T4) begin errors++; $display("FAIL t3_tile_new got %h exp %h", tile_data, T4); end
    checks++; if (tiles_sent !== 8'd3) begin errors++; $display("FAIL t3_sent3 got %0d exp 3", tiles_sent); end
    step();
    tile_ready = 1'b0;
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL t3_drain_valid got %b exp 0", tile_valid); end
    checks++; if (tiles_sent !== 8'd4) begin errors++; $display("FAIL t3_sent4 got %0d exp 4", tiles_sent); end
  endtask

  task automatic test_gapped_stream();
    for (int b = 8'h70; b <= 8'h7F; b++) begin
      pix_valid = 1'b0; pix_data = 8'hEE;
      step();
      send_byte(8'(b));
    end
    pix_valid = 1'b0;
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL t4_latency got %b exp 0", tile_valid); end
    step();
    checks++; if (tile_valid !== 1'b1) begin errors++; $display("FAIL t4_valid got %b exp 1", tile_valid); end
    checks++; if (tile_data !== T5) begin errors++; $display("FAIL t4_tile got %h exp %h", tile_data, T5); end
    checks++; if (filter_data !== F2) begin errors++; $display("FAIL t4_filter got %h exp %h", filter_data, F2); end
    checks++; if (tiles_sent !== 8'd4) begin errors++; $display("FAIL t4_sent got %0d exp 4", tiles_sent); end
  endtask

  task automatic test_reset_mid_load();
    for (int b = 0; b < 5; b++) send_byte(8'(8'hA0 + b));
    pix_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL t5_rst_valid got %b exp 0", tile_valid); end
    checks++; if (tile_data !== '0) begin errors++; $display("FAIL t5_rst_tile got %h exp 0", tile_data); end
    for (int b = 8'h81; b <= 8'h99; b++) send_byte(8'(b));
    pix_valid = 1'b0;
    step();
    checks++; if (tile_valid !== 1'b1) begin errors++; $display("FAIL t5_valid got %b exp 1", tile_valid); end
    checks++; if (filter_data !== F3) begin errors++; $display("FAIL t5_filter got %h exp %h", filter_data, F3); end
    checks++; if (tile_data !== T6) begin errors++; $display("FAIL t5_tile got %h exp %h", tile_data, T6); end
    checks++; if (tiles_sent !== 8'd0) begin errors++; $display("FAIL t5_sent got %0d exp 0", tiles_sent); end
  endtask

  task automatic test_back_to_back_wrap();
    int s = 0;
    int n = 0;
    int cyc = 0;
    int total = 9 + 256 * 16;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tile_ready = 1'b1;
    while (n < 256 && cyc < 6000) begin
      // With tile_ready held high, every cycle showing tile_valid is one accepted job.
      if (tile_valid) begin
        checks++;
        if (tile_data !== exp_tile(n)) begin
          errors++; $display("FAIL t6_job%0d got %h exp %h", n, tile_data, exp_tile(n));
        end
        checks++;
        if (tiles_sent !== 8'(n)) begin
          errors++; $display("FAIL t6_count%0d got %0d exp %0d", n, tiles_sent, 8'(n));
        end
        n++;
      end
      if (s < total) begin
        pix_valid = 1'b1;
        pix_data  = (s < 9) ? 8'(8'hC0 + s) : tile_byte((s - 9) / 16, (s - 9) % 16);
        if (pix_ready) s++;
      end else begin
        pix_valid = 1'b0;
      end
      step();
      cyc++;
    end
    pix_valid = 1'b0;
    tile_ready = 1'b0;
    checks++; if (n != 256) begin errors++; $display("FAIL t6_jobs_seen got %0d exp 256", n); end
    checks++; if (tiles_sent !== 8'd0) begin errors++; $display("FAIL t6_wrap got %0d exp 0", tiles_sent); end
    checks++; if (tile_valid !== 1'b0) begin errors++; $display("FAIL t6_drained got %b exp 0", tile_valid); end
    checks++; if (filter_data !== F4) begin errors++; $display("FAIL t6_filter got %h exp %h", filter_data, F4); end
  endtask

  initial begin
    test_reset();
    test_first_load();
    test_backpressure();
    test_reload();
    test_gapped_stream();
    test_reset_mid_load();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
